mp_addsub_ctrl: RTL

Multi-precision add/subtract sequencer built around the existing 32-bit add/sub datapath (addSub). It accepts NWORDS×32-bit operands through a valid/ready request. It iterates one 32-bit limb per cycle through a single addSub instance, least-significant limb first, chaining the carry. It returns the wide result, the carry-out and the signed-overflow flag through a valid/ready response.

---
 rtl/mp_addsub_pkg.sv | 9 +
 rtl/addSub.sv | 15 +
 rtl/mp_addsub_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/mp_addsub_pkg.sv
// mp_addsub_pkg: shared state encoding, default sizes and index-width helper for the multi-precision add/sub sequencer
package mp_addsub_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
    localparam int W_DEF      = 32;
    localparam int NWORDS_DEF = 4;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/addSub.sv
// addSub: W-bit add/sub datapath; D selects B inversion, Cin feeds the carry chain
module addSub #(
    parameter int W = 32
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         D,
    input  logic         Cin,
    output logic [W-1:0] S,
    output logic         Cout
);
    logic [W-1:0] b_eff;
    assign b_eff     = D ? ~B : B;
    assign {Cout, S} = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, Cin};
endmodule

// File: rtl/mp_addsub_ctrl.sv
// mp_addsub_ctrl: sequences NWORDS limbs through one addSub, LS limb first, carry chained
module mp_addsub_ctrl
    import mp_addsub_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W*NWORDS-1:0] req_a,
    input  logic [W*NWORDS-1:0] req_b,
    input  logic              req_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W*NWORDS-1:0] rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_ovf
);
    localparam int IW = idx_w(NWORDS);
    localparam int OW = W * NWORDS;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d, sub_q, sub_d;
    logic          cout_q, cout_d, ovf_q, ovf_d, valid_q, valid_d;
    logic [OW-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [W-1:0]  a_limb, b_limb, s_limb;
    logic          co;

    // subtraction is inversion of B plus carry-in of 1; the datapath D input stays 0
    assign a_limb = a_q[int'(idx_q)*W +: W];
    assign b_limb = sub_q ? ~b_q[int'(idx_q)*W +: W] : b_q[int'(idx_q)*W +: W];

    addSub #(.W(W)) u_addsub (
        .A   (a_limb),
        .B   (b_limb),
        .D   (1'b0),
        .Cin (carry_q),
        .S   (s_limb),
        .Cout(co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (req_valid) begin
                a_d     = req_a;
                b_d     = req_b;
                sub_d   = req_sub;
                idx_d   = '0;
                carry_d = req_sub;
                state_d = RUN;
            end
            RUN: begin
                sum_d[int'(idx_q)*W +: W] = s_limb;
                carry_d = co;
                if (idx_q == IW'(NWORDS - 1)) begin
                    idx_d   = '0;
                    cout_d  = co;
                    ovf_d   = (a_limb[W-1] == b_limb[W-1]) && (s_limb[W-1] != a_limb[W-1]);
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: if (rsp_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    // gated by rst_n so ready reads 0 while reset is held and 1 as soon as it is released
    assign req_ready = (state_q == IDLE) && rst_n;
    assign rsp_valid = valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;
endmodule
